// File: rtl/divu_pkg.sv
// ============================================================================
// divu_pkg : shared constants, state type and pin bit-IDs for divu_p4y2
// Revision : 1.0
// ============================================================================
`default_nettype none

package divu_pkg;

  localparam int P_WIDTH   = 4;
  localparam int Y_WIDTH   = 2;
  localparam int CNT_WIDTH = 2;

  localparam logic READY_TRUE  = 1'b1;
  localparam logic READY_FALSE = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Pin positions in the arithmetic tile's io_in/io_out vectors
  localparam int I_CLK_BITID   = 0;
  localparam int I_RST_BITID   = 1;
  localparam int I_P_BITID     = 2;
  localparam int I_Y_BITID     = 6;
  localparam int O_READY_BITID = 7;

endpackage

`default_nettype wire

// File: rtl/divu_step.sv
// ============================================================================
// divu_step : one restoring-division iteration (shift in, compare, subtract)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module divu_step
  import divu_pkg::*;
(
  input  logic [Y_WIDTH:0]   rem_in,
  input  logic               msb,
  input  logic [Y_WIDTH-1:0] divisor,
  output logic [Y_WIDTH:0]   rem_out,
  output logic               qbit
);

  logic [Y_WIDTH:0] shifted;
  logic [Y_WIDTH:0] div_ext;
  logic             unused_rem_top;

  // The partial remainder is always below the divisor, so its top bit is
  // shifted out without loss.
  assign unused_rem_top = rem_in[Y_WIDTH];

  assign shifted = {rem_in[Y_WIDTH-1:0], msb};
  assign div_ext = {1'b0, divisor};
  assign qbit    = (shifted >= div_ext);
  assign rem_out = qbit ? (shifted - div_ext) : shifted;

endmodule

`default_nettype wire

// File: rtl/divu_p4y2.sv
// ============================================================================
// divu_p4y2 : sequential restoring radix-2 unsigned divider, P / Y -> Q, R
// Revision  : 1.0
// ============================================================================
`default_nettype none

module divu_p4y2
  import divu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [P_WIDTH-1:0] p,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] q,
  output logic [Y_WIDTH-1:0] r,
  output logic               dz,
  output logic               vld,
  output logic               rdy
);

  state_t               state;
  logic [P_WIDTH-1:0]   dividend;
  logic [Y_WIDTH-1:0]   divisor;
  logic [Y_WIDTH:0]     rem;
  logic [Y_WIDTH:0]     rem_next;
  // Holds only the already-resolved quotient bits; the last bit comes from qbit
  logic [P_WIDTH-2:0]   quo;
  logic [CNT_WIDTH-1:0] count;
  logic                 qbit;

  divu_step u_step (
    .rem_in  (rem),
    .msb     (dividend[P_WIDTH-1]),
    .divisor (divisor),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  assign rdy = (state == IDLE) ? READY_TRUE : READY_FALSE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      q        <= '0;
      r        <= '0;
      dz       <= 1'b0;
      vld      <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (y == '0) begin
              q   <= '1;
              r   <= '0;
              dz  <= 1'b1;
              vld <= 1'b1;
            end else begin
              dividend <= p;
              divisor  <= y;
              rem      <= '0;
              quo      <= '0;
              count    <= CNT_WIDTH'(P_WIDTH - 1);
              state    <= CALC;
            end
          end
        end
        CALC: begin
          dividend <= {dividend[P_WIDTH-2:0], 1'b0};
          rem      <= rem_next;
          quo      <= {quo[P_WIDTH-3:0], qbit};
          count    <= count - CNT_WIDTH'(1);
          if (count == '0) begin
            q     <= {quo, qbit};
            r     <= rem_next[Y_WIDTH-1:0];
            dz    <= 1'b0;
            vld   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divu_p4y2.sv
// ============================================================================
// tb_divu_p4y2 : self-checking bench for divu_p4y2 against an arithmetic model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_divu_p4y2;

  localparam int MAXW = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] p;
  logic [1:0] y;
  logic [3:0] q;
  logic [1:0] r;
  logic       dz;
  logic       vld;
  logic       rdy;

  int total;
  int bad;

  int  lat;
  int  rdy_low;
  bit  tmo;

  divu_p4y2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .p     (p),
    .y     (y),
    .q     (q),
    .r     (r),
    .dz    (dz),
    .vld   (vld),
    .rdy   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: plain integer division, all-ones quotient on y==0
  function automatic logic [3:0] ref_q(input int pp, input int yy);
    return (yy == 0) ? 4'hF : 4'(pp / yy);
  endfunction

  function automatic logic [1:0] ref_r(input int pp, input int yy);
    return (yy == 0) ? 2'd0 : 2'(pp % yy);
  endfunction

  // Caller has raised start with operands; returns edges after acceptance until vld
  task automatic wait_vld(input bit scramble);
    lat = -1;
    rdy_low = 0;
    tmo = 1'b1;
    for (int k = 0; k <= MAXW; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
      else if (scramble) begin
        p = 4'($urandom);
        y = 2'($urandom);
      end
      if (!rdy) rdy_low++;
      if (vld) begin
        lat = k;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic issue(input int pp, input int yy);
    @(negedge clk);
    p = 4'(pp);
    y = 2'(yy);
    start = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    p = 4'd0;
    y = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({q, r, dz, vld, rdy} !== {4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_state: got q=%0d r=%0d dz=%b vld=%b rdy=%b want 0 0 0 0 1", q, r, dz, vld, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({vld, rdy} !== 2'b01) begin
      bad++; $display("FAIL post_reset_idle: got vld=%b rdy=%b want 0 1", vld, rdy);
    end
  endtask

  task automatic test_basic();
    int pv[4] = '{13, 15, 2, 0};
    int yv[4] = '{3, 1, 3, 2};
    for (int i = 0; i < 4; i++) begin
      issue(pv[i], yv[i]);
      wait_vld(1'b0);
      total++; if (tmo) begin
        bad++; $display("FAIL basic_timeout: p=%0d y=%0d no vld within %0d cycles", pv[i], yv[i], MAXW);
      end
      total++; if (lat !== 4 || rdy_low !== 4) begin
        bad++; $display("FAIL basic_latency: got lat=%0d rdy_low=%0d want 4 4", lat, rdy_low);
      end
      total++; if ({q, r, dz, rdy} !== {ref_q(pv[i], yv[i]), ref_r(pv[i], yv[i]), 1'b0, 1'b1}) begin
        bad++; $display("FAIL basic_result: p=%0d y=%0d got q=%0d r=%0d dz=%b rdy=%b want q=%0d r=%0d dz=0 rdy=1",
                        pv[i], yv[i], q, r, dz, rdy, ref_q(pv[i], yv[i]), ref_r(pv[i], yv[i]));
      end
      @(posedge clk);
      #1;
      total++; if (vld !== 1'b0) begin
        bad++; $display("FAIL vld_pulse: got vld=%b one cycle later want 0", vld);
      end
    end
  endtask

  task automatic test_div_zero();
    issue(9, 0);
    wait_vld(1'b0);
    total++; if (tmo || lat !== 0 || rdy_low !== 0) begin
      bad++; $display("FAIL dz_latency: got tmo=%b lat=%0d rdy_low=%0d want 0 0 0", tmo, lat, rdy_low);
    end
    total++; if ({q, r, dz} !== {4'd15, 2'd0, 1'b1}) begin
      bad++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b want 15 0 1", q, r, dz);
    end
    issue(6, 2);
    wait_vld(1'b0);
    total++; if (tmo || {q, r, dz} !== {4'd3, 2'd0, 1'b0}) begin
      bad++; $display("FAIL dz_follow: got tmo=%b q=%0d r=%0d dz=%b want 0 3 0 0", tmo, q, r, dz);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int k;
    issue(12, 2);
    lat = -1;
    k = 0;
    while (k <= MAXW) begin
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
      if (k == 1) begin
        p = 4'd7;
        y = 2'd3;
        start = 1'b1;
      end
      if (k == 2) start = 1'b0;
      if (vld) begin
        lat = k;
        break;
      end
      k++;
    end
    total++; if (lat !== 4 || {q, r, dz} !== {4'd6, 2'd0, 1'b0}) begin
      bad++; $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d dz=%b want 4 6 0 0", lat, q, r, dz);
    end
    // Start raised in the vld cycle must be accepted on the very next edge
    p = 4'd7;
    y = 2'd3;
    start = 1'b1;
    wait_vld(1'b0);
    total++; if (tmo || lat !== 4 || {q, r, dz} !== {4'd2, 2'd1, 1'b0}) begin
      bad++; $display("FAIL back_to_back: got tmo=%b lat=%0d q=%0d r=%0d dz=%b want 0 4 2 1 0", tmo, lat, q, r, dz);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(11, 3);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({q, r, dz, vld, rdy} !== {4'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL reset_mid: got q=%0d r=%0d dz=%b vld=%b rdy=%b want 0 0 0 0 1", q, r, dz, vld, rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (vld) seen++;
    end
    total++; if (seen !== 0 || rdy !== 1'b1) begin
      bad++; $display("FAIL reset_abort: got %0d vld pulses rdy=%b want 0 pulses rdy=1", seen, rdy);
    end
  endtask

  task automatic test_exhaustive();
    for (int pp = 0; pp < 16; pp++) begin
      for (int yy = 0; yy < 4; yy++) begin
        issue(pp, yy);
        wait_vld(1'b0);
        total++;
        if (tmo) begin
          bad++; $display("FAIL exh_timeout: p=%0d y=%0d", pp, yy);
        end else if (yy == 0) begin
          if ({q, r, dz} !== {4'd15, 2'd0, 1'b1}) begin
            bad++; $display("FAIL exh_dz: p=%0d got q=%0d r=%0d dz=%b want 15 0 1", pp, q, r, dz);
          end
        end else if (dz !== 1'b0 || (int'(q) * yy + int'(r)) != pp || int'(r) >= yy) begin
          bad++; $display("FAIL exh_identity: p=%0d y=%0d got q=%0d r=%0d dz=%b", pp, yy, q, r, dz);
        end
      end
    end
  endtask

  task automatic test_random();
    int pp, yy, gap;
    for (int i = 0; i < 40; i++) begin
      pp = int'($urandom_range(15, 0));
      yy = int'($urandom_range(3, 0));
      gap = int'($urandom_range(2, 0));
      repeat (gap) @(posedge clk);
      issue(pp, yy);
      wait_vld(1'b1);
      total++; if (tmo || {q, r, dz} !== {ref_q(pp, yy), ref_r(pp, yy), (yy == 0)}) begin
        bad++; $display("FAIL random: p=%0d y=%0d got tmo=%b q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                        pp, yy, tmo, q, r, dz, ref_q(pp, yy), ref_r(pp, yy), (yy == 0));
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_and_back_to_back();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/divu_p4y2.md
Name: divu_p4y2

Overview:
Sequential unsigned divider, the inverse operation of the team's 2x2 unsigned multiplier. Divides a 4-bit dividend P by a 2-bit divisor Y, producing a 4-bit quotient Q and a 2-bit remainder R. It is a restoring radix-2 design that resolves one quotient bit per clock, with a start/ready/valid handshake. It sits beside the multiplier in the TT03 arithmetic tile, with pins mapped through the same io_in/io_out bit-ID scheme.

Parameters:
P_WIDTH, 4, dividend and quotient width
Y_WIDTH, 2, divisor and remainder width
CNT_WIDTH, 2, iteration counter width; equals clog2(P_WIDTH)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when rdy=1
p  input  P_WIDTH  dividend; captured when start is accepted
y  input  Y_WIDTH  divisor; captured when start is accepted
q  output  P_WIDTH  quotient; registered, holds the last result
r  output  Y_WIDTH  remainder; registered, holds the last result
dz  output  1  divide-by-zero flag for the last result; registered
vld  output  1  one-cycle pulse when q/r/dz update
rdy  output  1  1 = idle and able to accept start (READY_TRUE)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, q=0, r=0, dz=0, vld=0, rdy=1, all working registers=0. Reset mid-calculation aborts the operation; no vld is produced.
- States: IDLE and CALC. rdy=1 if and only if state=IDLE.
- IDLE, start=1, y!=0: capture p into the dividend shift register and y into the divisor register; clear the partial remainder (Y_WIDTH+1 bits); count=P_WIDTH-1; go to CALC.
- IDLE, start=1, y==0: no CALC. On the next edge, q=all ones, r=0, dz=1, vld=1. Stay in IDLE (latency 1, rdy stays 1).
- IDLE, start=0: hold. vld=0 on the edge after any pulse.
- CALC, each edge:
  - t = {rem[Y_WIDTH-1:0], dividend MSB}
  - if t >= divisor: rem = t - divisor and qbit = 1; else rem = t and qbit = 0
  - shift the dividend left; shift qbit into the quotient LSB
  - count decrements
- CALC, edge where count==0: perform the final iteration, load q=final quotient, r=final rem[Y_WIDTH-1:0], dz=0, vld=1, go to IDLE.
- Latency: start accepted at edge E0. q/r valid and vld=1 after edge E0+P_WIDTH (E4). rdy is low for exactly P_WIDTH cycles.
- start while rdy=0: ignored and not queued. Operands p/y may change freely during CALC.
- start=1 in the same cycle vld=1 (back-to-back): accepted normally, giving a 1-in-(P_WIDTH+1)-cycle issue rate.
- q, r, dz change only on completion or reset. They never show intermediate values.
- Arithmetic: the partial remainder is Y_WIDTH+1 bits wide so the shifted value never overflows. The final remainder is always < y and fits in Y_WIDTH bits. Invariant: p == q*y + r whenever dz=0.

Decomposition:
- Package divu_pkg holds:
  - the P_WIDTH/Y_WIDTH/CNT_WIDTH constants
  - READY_TRUE/READY_FALSE
  - the state typedef {IDLE, CALC}
  - the pin bit-IDs (I_CLK_BITID=0, I_RST_BITID=1, I_P_BITID, I_Y_BITID, O_READY_BITID=7)
- One sub-module is natural: divu_step, purely combinational. It takes rem_in, dividend MSB and divisor, and returns rem_out and qbit, using a Y_WIDTH+1-bit compare/subtract.
- The top level holds the FSM, counter, shift registers and output registers.

Test Plan:
1. Reset, then p=13, y=3, start pulse -> rdy=0 for 4 cycles; at E4 vld=1, q=4, r=1, dz=0, rdy=1.
2. p=15, y=1 -> q=15, r=0. Then p=2, y=3 -> q=0, r=2. Then p=0, y=2 -> q=0, r=0.
3. p=9, y=0, start -> vld=1 on the next edge, q=15, r=0, dz=1, rdy never drops. A following p=6, y=2 -> q=3, r=0, dz=0.
4. Start p=12, y=2. Pulse start with p=7, y=3 at E2 -> ignored; result q=6, r=0. Then a back-to-back start in the vld cycle with p=7, y=3 -> q=2, r=1 at E0+4.
5. Start p=11, y=3. Assert rst_n=0 mid-CALC (between E2 and E3) -> q=0, r=0, dz=0, vld=0, rdy=1 immediately, with no later vld.
6. Exhaustive: all 16x4 operand pairs -> p == q*y + r and r < y for y!=0; dz=1, q=15, r=0 for y=0.
